// File: rtl/calc_arbiter.sv
// calc_arbiter: grants one of two keyIn requesters ownership of a shared
// calculator, forwards its beats, and returns the result or a timeout.
module calc_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        ck,
  input  logic        rst,
  input  logic        r0_valid,
  input  logic [19:0] r0_data,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [19:0] r1_data,
  output logic        r1_ready,
  output logic        calc_valid,
  output logic [19:0] calc_data,
  input  logic [15:0] calc_result,
  input  logic        calc_stackOverflow,
  input  logic        calc_unexpectedDone,
  input  logic        calc_protocolError,
  input  logic        calc_dataOverflow,
  input  logic        calc_finished,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_result,
  output logic [4:0]  resp_err,
  output logic        drop
);

  localparam logic [3:0] OP_START = 4'h1;
  localparam logic [3:0] OP_DONE  = 4'h8;
  localparam int TLIM = (TIMEOUT > 255) ? 255 : TIMEOUT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner;
  logic        r_last;
  logic [7:0]  r_timer;
  logic        r_calc_valid;
  logic [19:0] r_calc_data;
  logic        r_drop;
  logic        r_resp_id;
  logic [15:0] r_resp_result;
  logic [4:0]  r_resp_err;

  logic        w_st0;
  logic        w_st1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_fwd;
  logic [19:0] w_fwd_data;
  logic        w_drop;
  logic        w_grant;
  logic        w_gid;
  logic        w_cap;
  logic        w_tmo;
  logic        w_exp;

  assign w_st0 = r0_valid && (r0_data[19:16] == OP_START);
  assign w_st1 = r1_valid && (r1_data[19:16] == OP_START);
  // r_last names the requester granted most recently; a tie goes to the other
  assign w_gnt0 = w_st0 && (!w_st1 || r_last);
  assign w_gnt1 = w_st1 && (!w_st0 || !r_last);
  assign w_exp = (int'(r_timer) + 1) >= TLIM;

  always_ff @(posedge ck) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    r0_ready   = 1'b0;
    r1_ready   = 1'b0;
    w_fwd      = 1'b0;
    w_fwd_data = r0_data;
    w_drop     = 1'b0;
    w_grant    = 1'b0;
    w_gid      = 1'b0;
    w_cap      = 1'b0;
    w_tmo      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        r0_ready = r0_valid && (!w_st0 || w_gnt0);
        r1_ready = r1_valid && (!w_st1 || w_gnt1);
        w_drop = (r0_valid && !w_st0) || (r1_valid && !w_st1);
        if (w_gnt0 || w_gnt1) begin
          w_next     = S_OWN;
          w_fwd      = 1'b1;
          w_grant    = 1'b1;
          w_gid      = w_gnt1;
          w_fwd_data = w_gnt1 ? r1_data : r0_data;
        end
      end
      S_OWN: begin
        r0_ready   = !r_owner;
        r1_ready   = r_owner;
        w_fwd      = r_owner ? r1_valid : r0_valid;
        w_fwd_data = r_owner ? r1_data : r0_data;
        if (w_fwd && (w_fwd_data[19:16] == OP_DONE)) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (calc_finished) begin
          w_cap  = 1'b1;
          w_next = S_RESP;
        end else if (w_exp) begin
          w_tmo  = 1'b1;
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_owner       <= 1'b0;
      r_last        <= 1'b1;
      r_timer       <= 8'd0;
      r_calc_valid  <= 1'b0;
      r_calc_data   <= 20'd0;
      r_drop        <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= 16'd0;
      r_resp_err    <= 5'd0;
    end else begin
      r_calc_valid <= w_fwd;
      r_drop       <= w_drop;
      if (w_fwd) r_calc_data <= w_fwd_data;
      if (w_grant) begin
        r_owner <= w_gid;
        r_last  <= w_gid;
      end
      if (r_state != S_WAIT)   r_timer <= 8'd0;
      else if (r_timer != 8'hFF) r_timer <= r_timer + 8'd1;
      if (w_cap) begin
        r_resp_id     <= r_owner;
        r_resp_result <= calc_result;
        r_resp_err    <= {1'b0, calc_stackOverflow, calc_unexpectedDone,
                          calc_protocolError, calc_dataOverflow};
      end else if (w_tmo) begin
        r_resp_id     <= r_owner;
        r_resp_result <= 16'd0;
        r_resp_err    <= 5'b10000;
      end
    end
  end

  assign calc_valid  = r_calc_valid;
  assign calc_data   = r_calc_data;
  assign drop        = r_drop;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_err    = r_resp_err;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed, table-driven bench for calc_arbiter.
module tb_calc_arbiter;

  logic        ck = 1'b0;
  logic        rst;
  logic        r0_valid;
  logic [19:0] r0_data;
  logic        r0_ready;
  logic        r1_valid;
  logic [19:0] r1_data;
  logic        r1_ready;
  logic        calc_valid;
  logic [19:0] calc_data;
  logic [15:0] calc_result;
  logic        calc_so;
  logic        calc_ud;
  logic        calc_pe;
  logic        calc_do;
  logic        calc_finished;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_result;
  logic [4:0]  resp_err;
  logic        drop;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [19:0] S3 = 20'h10003;
  localparam logic [19:0] S9 = 20'h10009;
  localparam logic [19:0] SA = 20'h1000A;
  localparam logic [19:0] E5 = 20'h20005;
  localparam logic [19:0] E7 = 20'h20007;
  localparam logic [19:0] A1 = 20'h40001;
  localparam logic [19:0] DN = 20'h80000;

  calc_arbiter #(.TIMEOUT(16)) dut (
    .ck(ck),
    .rst(rst),
    .r0_valid(r0_valid),
    .r0_data(r0_data),
    .r0_ready(r0_ready),
    .r1_valid(r1_valid),
    .r1_data(r1_data),
    .r1_ready(r1_ready),
    .calc_valid(calc_valid),
    .calc_data(calc_data),
    .calc_result(calc_result),
    .calc_stackOverflow(calc_so),
    .calc_unexpectedDone(calc_ud),
    .calc_protocolError(calc_pe),
    .calc_dataOverflow(calc_do),
    .calc_finished(calc_finished),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id(resp_id),
    .resp_result(resp_result),
    .resp_err(resp_err),
    .drop(drop)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [19:0] d0;
    logic        v1;
    logic [19:0] d1;
    logic        fin;
    logic [15:0] res;
    logic [3:0]  flg;
    logic        rr;
    logic        e_r0r;
    logic        e_r1r;
    logic        e_cv;
    logic [19:0] e_cd;
    logic        e_rv;
    logic        e_drop;
    logic        e_id;
    logic [15:0] e_res;
    logic [4:0]  e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic rs, input logic v0, input logic [19:0] d0,
    input logic v1, input logic [19:0] d1, input logic fin,
    input logic [15:0] res, input logic [3:0] flg, input logic rr,
    input logic r0r, input logic r1r, input logic cv,
    input logic [19:0] cd, input logic rv, input logic dr,
    input logic id, input logic [15:0] eres, input logic [4:0] err);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.fin = fin; v.res = res; v.flg = flg; v.rr = rr;
    v.e_r0r = r0r; v.e_r1r = r1r; v.e_cv = cv; v.e_cd = cd;
    v.e_rv = rv; v.e_drop = dr; v.e_id = id; v.e_res = eres;
    v.e_err = err;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
  endtask

  task automatic idle_in();
    r0_valid = 0; r0_data = 0; r1_valid = 0; r1_data = 0;
    calc_finished = 0; calc_result = 0;
    {calc_so, calc_ud, calc_pe, calc_do} = 4'h0;
    resp_ready = 0;
  endtask

  initial begin
    rst = 1;
    idle_in();
    repeat (2) @(negedge ck);
    #1;
    chk("rst_r0_ready", -1, 32'(r0_ready), 0);
    chk("rst_r1_ready", -1, 32'(r1_ready), 0);
    chk("rst_calc_valid", -1, 32'(calc_valid), 0);
    chk("rst_calc_data", -1, 32'(calc_data), 0);
    chk("rst_resp_valid", -1, 32'(resp_valid), 0);
    chk("rst_resp_id", -1, 32'(resp_id), 0);
    chk("rst_resp_result", -1, 32'(resp_result), 0);
    chk("rst_resp_err", -1, 32'(resp_err), 0);
    chk("rst_drop", -1, 32'(drop), 0);

    // rst rv0 d0 rv1 d1 fin res flg rr | r0r r1r cv cd rv drop id res err
    add(0,0,0,0,0,  0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,1,E7, 0,0,0,0, 0,1,0,0,0,0,0,0,0);
    add(0,0,0,0,0,  0,0,0,0, 0,0,0,0,0,1,0,0,0);
    add(0,0,0,0,0,  0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,1,S3,1,S9, 0,0,0,0, 1,0,0,0,0,0,0,0,0);
    add(0,1,E5,1,S9, 0,0,0,0, 1,0,1,S3,0,0,0,0,0);
    add(0,1,A1,1,S9, 1,16'h1234,4'hF,0, 1,0,1,E5,0,0,0,0,0);
    add(0,1,DN,1,S9, 0,0,0,0, 1,0,1,A1,0,0,0,0,0);
    add(0,0,0,1,S9,  0,0,0,0, 0,0,1,DN,0,0,0,0,0);
    add(0,0,0,1,S9,  1,16'h0008,0,0, 0,0,0,0,0,0,0,0,0);
    for (int k = 0; k < 5; k++)
      add(0,0,0,1,S9, 0,0,0,0, 0,0,0,0,1,0,0,16'h0008,0);
    add(0,0,0,1,S9,  0,0,0,1, 0,0,0,0,1,0,0,16'h0008,0);
    add(0,1,S3,1,S9, 0,0,0,0, 0,1,0,0,0,0,0,0,0);
    add(0,1,S3,1,DN, 0,0,0,0, 0,1,1,S9,0,0,0,0,0);
    add(0,1,S3,0,0,  0,0,0,0, 0,0,1,DN,0,0,0,0,0);
    for (int k = 0; k < 15; k++)
      add(0,1,S3,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,1,S3,0,0,  0,0,0,1, 0,0,0,0,1,0,1,0,5'b10000);
    add(0,1,S3,0,0,  0,0,0,0, 1,0,0,0,0,0,0,0,0);
    add(0,1,E5,0,0,  0,0,0,0, 1,0,1,S3,0,0,0,0,0);
    add(1,0,0,0,0,   0,0,0,0, 1,0,1,E5,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,0,1,SA,  0,0,0,0, 0,1,0,0,0,0,0,0,0);
    add(0,0,0,1,DN,  0,0,0,0, 0,1,1,SA,0,0,0,0,0);
    add(0,0,0,0,0,   1,16'hBEEF,4'hA,0, 0,0,1,DN,0,0,0,0,0);
    add(0,0,0,0,0,   0,0,0,1, 0,0,0,0,1,0,1,16'hBEEF,5'b01010);
    add(0,0,0,0,0,   0,0,0,0, 0,0,0,0,0,0,0,0,0);

    @(negedge ck);
    rst = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      r0_valid = tbl[i].v0; r0_data = tbl[i].d0;
      r1_valid = tbl[i].v1; r1_data = tbl[i].d1;
      calc_finished = tbl[i].fin; calc_result = tbl[i].res;
      {calc_so, calc_ud, calc_pe, calc_do} = tbl[i].flg;
      resp_ready = tbl[i].rr;
      #1;
      chk("r0_ready", i, 32'(r0_ready), 32'(tbl[i].e_r0r));
      chk("r1_ready", i, 32'(r1_ready), 32'(tbl[i].e_r1r));
      chk("calc_valid", i, 32'(calc_valid), 32'(tbl[i].e_cv));
      chk("resp_valid", i, 32'(resp_valid), 32'(tbl[i].e_rv));
      chk("drop", i, 32'(drop), 32'(tbl[i].e_drop));
      if (tbl[i].e_cv)
        chk("calc_data", i, 32'(calc_data), 32'(tbl[i].e_cd));
      if (tbl[i].e_rv) begin
        chk("resp_id", i, 32'(resp_id), 32'(tbl[i].e_id));
        chk("resp_result", i, 32'(resp_result), 32'(tbl[i].e_res));
        chk("resp_err", i, 32'(resp_err), 32'(tbl[i].e_err));
      end
      @(negedge ck);
    end

    // finished arriving on the expiry cycle wins over the timeout
    rst = 0;
    idle_in();
    r0_valid = 1; r0_data = S3;
    #1 chk("exp_grant", 100, 32'(r0_ready), 1);
    @(negedge ck);
    r0_data = DN;
    #1 chk("exp_fwd_start", 101, 32'(calc_data), 32'(S3));
    @(negedge ck);
    r0_valid = 0; r0_data = 0;
    #1 chk("exp_fwd_done", 102, 32'(calc_data), 32'(DN));
    for (int k = 1; k < 15; k++) begin
      @(negedge ck);
      #1 chk("exp_wait", 102 + k, 32'(resp_valid), 0);
    end
    @(negedge ck);
    calc_finished = 1; calc_result = 16'h0055;
    #1 chk("exp_last_wait", 117, 32'(resp_valid), 0);
    @(negedge ck);
    calc_finished = 0; calc_result = 0; resp_ready = 1;
    #1;
    chk("exp_resp_valid", 118, 32'(resp_valid), 1);
    chk("exp_resp_result", 118, 32'(resp_result), 32'h55);
    chk("exp_resp_err", 118, 32'(resp_err), 0);
    chk("exp_resp_id", 118, 32'(resp_id), 0);
    @(negedge ck);
    resp_ready = 0;
    #1 chk("exp_back_idle", 119, 32'(resp_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
